// File: rtl/vga_framebuffer_reader_pkg.sv
// Shared timing constants, clear-engine states and address helper
// for the VGA framebuffer reader.
package vga_framebuffer_reader_pkg;

    localparam logic [10:0] H_ACTIVE   = 11'd640;
    localparam logic [10:0] V_ACTIVE   = 11'd480;
    localparam logic [10:0] H_LAST     = 11'd840;
    localparam logic [10:0] V_LAST     = 11'd520;
    localparam int          SCALE_LOG2 = 2;
    localparam logic [7:0]  FB_W       = 8'd160;
    localparam logic [6:0]  FB_H       = 7'd120;
    localparam int          FB_DEPTH   = 19200;
    localparam int          ADDR_W     = 15;
    localparam logic [14:0] FB_LAST    = 15'(FB_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CLEAR = 2'd2
    } clr_state_t;

    // Row-major cell address: r*160 + c as two shifts and an add.
    function automatic logic [14:0] fb_addr(
        input logic [6:0] r,
        input logic [7:0] c
    );
        return {1'b0, r, 7'b0} + {3'b0, r, 5'b0} + {7'b0, c};
    endfunction

endpackage

// File: rtl/vga_framebuffer_reader_fb_ram_dp.sv
// Simple dual-port framebuffer RAM: one write port, one synchronous
// read port, no reset on the storage.
module fb_ram_dp
    import vga_framebuffer_reader_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [2:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [2:0]        rdata
);

    logic [2:0] mem [FB_DEPTH];

    // Read samples the array before a same-edge write lands (old data).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Pixel source for a 640x480 VGA driver: scans a 160x120 3-bit
// framebuffer at 4x, with a write port and a vblank clear engine.
module vga_framebuffer_reader
    import vga_framebuffer_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] posX,
    input  logic [10:0] posY,
    output logic [2:0]  pixelIn,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [2:0]  wr_data,
    input  logic        clear_req,
    input  logic [2:0]  clear_color,
    output logic        busy,
    output logic        wr_err,
    output logic        frame_start
);

    clr_state_t        state;
    logic [14:0]       clr_addr;
    logic [2:0]        clr_color;
    logic [10:0]       nx;
    logic [10:0]       ny;
    logic              vis;
    logic              at_vblank;
    logic              pix_vis;
    logic [14:0]       rd_addr;
    logic [2:0]        rd_data;
    logic              wr_fire;
    logic              wr_in_range;
    logic              ram_we;
    logic [14:0]       ram_waddr;
    logic [2:0]        ram_wdata;

    // Predict the position the driver will present next cycle.
    always_comb begin
        nx = posX + 11'd1;
        ny = posY;
        if (posX >= H_LAST) begin
            nx = '0;
            ny = (posY >= V_LAST) ? '0 : posY + 11'd1;
        end
    end

    assign vis       = (nx < H_ACTIVE) && (ny < V_ACTIVE);
    assign at_vblank = (nx == '0) && (ny == V_ACTIVE);
    assign rd_addr   = vis ? fb_addr(ny[8:2], nx[9:2]) : '0;

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (wr_x < FB_W) && (wr_y < FB_H);

    // Clear engine owns the write port; otherwise it serves the requester.
    always_comb begin
        ram_we    = wr_fire && wr_in_range;
        ram_waddr = fb_addr(wr_y, wr_x);
        ram_wdata = wr_data;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = clr_color;
        end
    end

    fb_ram_dp u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Clear FSM with registered busy / wr_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            clr_addr  <= '0;
            clr_color <= '0;
            busy      <= 1'b0;
            wr_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= ARMED;
                        clr_color <= clear_color;
                        busy      <= 1'b1;
                        wr_ready  <= 1'b0;
                    end else begin
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end
                end
                ARMED: begin
                    if (at_vblank) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr <= clr_addr + 15'd1;
                    if (clr_addr == FB_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky out-of-range write flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_err <= 1'b0;
        end else if (wr_fire && !wr_in_range) begin
            wr_err <= 1'b1;
        end
    end

    // Visibility and frame-start flags aligned with the RAM read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_vis     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_vis     <= vis;
            frame_start <= (nx == '0) && (ny == '0);
        end
    end

    assign pixelIn = pix_vis ? rd_data : 3'd0;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Randomised self-checking bench for vga_framebuffer_reader against a
// cell-array model of the framebuffer and the visible window.
module tb_vga_framebuffer_reader;

    localparam int HL = 840;
    localparam int VL = 520;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] posX = '0;
    logic [10:0] posY = '0;
    logic [2:0]  pixelIn;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_x = '0;
    logic [6:0]  wr_y = '0;
    logic [2:0]  wr_data = '0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic        busy;
    logic        wr_err;
    logic        frame_start;

    always #5 clk = ~clk;

    vga_framebuffer_reader dut (
        .clk         (clk),
        .rst         (rst),
        .posX        (posX),
        .posY        (posY),
        .pixelIn     (pixelIn),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .busy        (busy),
        .wr_err      (wr_err),
        .frame_start (frame_start)
    );

    logic [2:0] fb    [120][160];
    bit         known [120][160];
    bit         err_exp = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         px = 0;
    int         py = 0;
    bit         chk_pix = 1'b0;
    int         cnt;
    int         rx;
    int         ry;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pix(input int x, input int y);
        if (x >= 640 || y >= 480) return 0;
        return int'(fb[y/4][x/4]);
    endfunction

    function automatic bit pix_known(input int x, input int y);
        if (x >= 640 || y >= 480) return 1'b1;
        return known[y/4][x/4];
    endfunction

    task automatic goto(input int x, input int y);
        px   = x;
        py   = y;
        posX = px[10:0];
        posY = py[10:0];
    endtask

    // One driver clock: advance the raster and optionally check outputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (px >= HL) begin
            px = 0;
            py = (py >= VL) ? 0 : py + 1;
        end else begin
            px++;
        end
        posX = px[10:0];
        posY = py[10:0];
        if (chk_pix) begin
            if (pix_known(px, py))
                chk($sformatf("pix(%0d,%0d)", px, py), int'(pixelIn), exp_pix(px, py));
            chk($sformatf("fs(%0d,%0d)", px, py), int'(frame_start), int'(px == 0 && py == 0));
        end
    endtask

    // Check n consecutive positions starting at (x,y).
    task automatic scan_from(input int x, input int y, input int n);
        if (x == 0) goto(HL, (y == 0) ? VL : y - 1);
        else goto(x - 1, y);
        chk_pix = 1'b1;
        repeat (n) cyc();
        chk_pix = 1'b0;
    endtask

    task automatic rscans(input int n);
        for (int i = 0; i < n; i++)
            scan_from($urandom_range(0, HL), $urandom_range(0, VL), 6);
    endtask

    task automatic wr(input int x, input int y, input int d);
        int n;
        chk_pix  = 1'b0;
        wr_x     = x[7:0];
        wr_y     = y[6:0];
        wr_data  = d[2:0];
        wr_valid = 1'b1;
        n = 0;
        while (wr_ready !== 1'b1 && n < 50000) begin
            cyc();
            n++;
        end
        chk("wr_wait", int'(wr_ready), 1);
        cyc();
        wr_valid = 1'b0;
        if (x < 160 && y < 120) begin
            fb[y][x]    = d[2:0];
            known[y][x] = 1'b1;
        end else begin
            err_exp = 1'b1;
        end
    endtask

    task automatic fill_model(input logic [2:0] c, input int n);
        for (int a = 0; a < n; a++) begin
            fb[a/160][a%160]    = c;
            known[a/160][a%160] = 1'b1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (2) cyc();
        chk("rst_pix", int'(pixelIn), 0);
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(wr_err), 0);
        chk("rst_fs", int'(frame_start), 0);
        rst = 1'b1;
        cyc();
        chk("ready_after_rst", int'(wr_ready), 1);

        // Corner cells and frame-start pulse.
        wr(0, 0, 4);
        wr(159, 119, 1);
        for (int y = 0; y < 4; y++) scan_from(0, y, 8);
        for (int y = 476; y < 480; y++) scan_from(632, y, 12);
        scan_from(835, 520, 12);

        // Whole-buffer pattern.
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                wr(x, y, (x + y) & 7);
        scan_from(5, 500, 10);
        scan_from(630, 478, 16);
        scan_from(830, 479, 16);
        rscans(150);

        // Out-of-range write is dropped and sticky.
        wr(160, 5, 7);
        chk("wr_err_set", int'(wr_err), int'(err_exp));
        rscans(40);
        rx = $urandom_range(0, 159);
        ry = $urandom_range(0, 119);
        wr(rx, ry, $urandom_range(0, 7));
        chk("wr_err_sticky", int'(wr_err), 1);
        scan_from(rx * 4, ry * 4, 4);
        for (int i = 0; i < 30; i++)
            wr($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
        rscans(60);

        // Clear armed together with a write to (3,3).
        goto(50, 100);
        chk("ready_pre_clear", int'(wr_ready), 1);
        wr_x = 8'd3; wr_y = 7'd3; wr_data = 3'b101; wr_valid = 1'b1;
        clear_color = 3'b010; clear_req = 1'b1;
        cyc();
        wr_valid = 1'b0; clear_req = 1'b0; clear_color = 3'b101;
        fb[3][3] = 3'b101;
        chk("busy_armed", int'(busy), 1);
        chk("ready_armed", int'(wr_ready), 0);
        wr_x = 8'd0; wr_y = 7'd0; wr_data = 3'b111; wr_valid = 1'b1;
        repeat (5) cyc();
        wr_valid = 1'b0;
        scan_from(0, 0, 4);
        scan_from(12, 12, 4);
        scan_from(0, 100, 300);
        chk("busy_wait", int'(busy), 1);
        goto(830, 479);
        chk_pix = 1'b1;
        repeat (11) cyc();
        chk("busy_vblank", int'(busy), 1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 25000) begin
            cnt++;
            clear_req = (cnt == 100);
            if (cnt == 100) clear_color = 3'b111;
            cyc();
        end
        clear_req = 1'b0;
        chk_pix = 1'b0;
        chk("clear_cycles", cnt, 19200);
        chk("ready_after_clear", int'(wr_ready), 1);
        fill_model(3'b010, 19200);
        repeat (20) cyc();
        chk("busy_idle", int'(busy), 0);
        scan_from(12, 12, 4);
        scan_from(0, 0, 8);
        rscans(120);

        // Reset in the middle of a clear.
        for (int i = 0; i < 30; i++)
            wr($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
        wr($urandom_range(0, 159), 119, 3'b001);
        goto(20, 300);
        clear_color = 3'b110; clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        goto(830, 479);
        repeat (11) cyc();
        repeat (8003) cyc();
        chk("busy_mid_clear", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("arst_pix", int'(pixelIn), 0);
        chk("arst_ready", int'(wr_ready), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_err", int'(wr_err), 0);
        chk("arst_fs", int'(frame_start), 0);
        fill_model(3'b110, 8003);
        err_exp = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        chk("ready_after_arst", int'(wr_ready), 1);
        chk("busy_after_arst", int'(busy), 0);
        chk("err_after_arst", int'(wr_err), int'(err_exp));
        scan_from(0, 200, 24);
        scan_from(600, 196, 40);
        scan_from(0, 476, 640);
        rscans(120);
        rx = $urandom_range(0, 159);
        ry = $urandom_range(60, 119);
        wr(rx, ry, $urandom_range(0, 7));
        scan_from(rx * 4, ry * 4, 4);
        chk("err_final", int'(wr_err), int'(err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
